// File: rtl/dmem_arb_pkg.sv
// Shared constants for the two-port data-memory arbiter: lock-state encoding,
// priority-mode selectors and default memory geometry.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_e;

    // Bit N set means port N may be granted in this lock state.
    function automatic logic [1:0] lock_allow(input lock_state_e st);
        case (st)
            LOCKED0: lock_allow = 2'b01;
            LOCKED1: lock_allow = 2'b10;
            default: lock_allow = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way winner select: lock filter first, then round-robin or
// fixed priority when both eligible ports are requesting.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic        req0,
    input  logic        req1,
    input  logic        rr_last,
    input  lock_state_e lock_state,
    output logic        win0,
    output logic        win1
);

    logic [1:0] elig;

    assign elig = {req1, req0} & lock_allow(lock_state);

    // rr_last names the previous winner, so the other port wins a tie.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (elig == 2'b11) begin
            if (PRIO_MODE == PRIO_FIXED || rr_last) begin
                win0 = 1'b1;
            end else begin
                win1 = 1'b1;
            end
        end else begin
            win0 = elig[0];
            win1 = elig[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port dmem (CPU MEM stage, debug port).
// Optional bus locking is compiled in with DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        we_v;
    logic [1:0]        win_v;
    logic [1:0]        gnt_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [DATA_W-1:0] wdata_v [2];
    logic              rr_last_q;
    logic              rr_last_d;
    lock_state_e       lock_state;

    assign we_v       = {we1, we0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;

    dmem_arb_pick #(
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .req0       (req0),
        .req1       (req1),
        .rr_last    (rr_last_q),
        .lock_state (lock_state),
        .win0       (win_v[0]),
        .win1       (win_v[1])
    );

    // Masking with rst_n keeps a write presented during reset off the memory.
    assign gnt_v = win_v & {2{rst_n}};
    assign gnt0  = gnt_v[0];
    assign gnt1  = gnt_v[1];

    always_comb begin
        mem_ena   = |gnt_v;
        mem_wena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            if (gnt_v[i]) begin
                mem_wena  = we_v[i];
                mem_addr  = addr_v[i];
                mem_wdata = wdata_v[i];
            end
        end
    end

    // Per-port read return: mem_rdata is captured only on a granted read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic              rd_hit;
            logic              rvalid_d;
            logic              rvalid_q;
            logic [DATA_W-1:0] rdata_d;
            logic [DATA_W-1:0] rdata_q;

            assign rd_hit   = gnt_v[gi] & ~we_v[gi];
            assign rvalid_d = rd_hit;
            assign rdata_d  = rd_hit ? mem_rdata : rdata_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rvalid_d;
                    rdata_q  <= rdata_d;
                end
            end
        end
    endgenerate

    assign rvalid0 = g_port[0].rvalid_q;
    assign rvalid1 = g_port[1].rvalid_q;
    assign rdata0  = g_port[0].rdata_q;
    assign rdata1  = g_port[1].rdata_q;

    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt_v[0]) begin
            rr_last_d = 1'b0;
        end else if (gnt_v[1]) begin
            rr_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    lock_state_e lock_q;

    // A lock is held only while its owner keeps requesting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q <= UNLOCKED;
        end else begin
            case (lock_q)
                UNLOCKED: begin
                    if (gnt_v[0] && lock0) begin
                        lock_q <= LOCKED0;
                    end else if (gnt_v[1] && lock1) begin
                        lock_q <= LOCKED1;
                    end
                end
                LOCKED0: begin
                    if (!req0 || (gnt_v[0] && !lock0)) begin
                        lock_q <= UNLOCKED;
                    end
                end
                LOCKED1: begin
                    if (!req1 || (gnt_v[1] && !lock1)) begin
                        lock_q <= UNLOCKED;
                    end
                end
                default: lock_q <= UNLOCKED;
            endcase
        end
    end

    assign lock_state = lock_q;
`else
    logic unused_lock;

    assign lock_state  = UNLOCKED;
    assign unused_lock = lock0 ^ lock1;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus,
// each with its own memory model behind it.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;

    logic        r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_ena, r_wena;
    logic [7:0]  r_addr;
    logic [15:0] r_rdata0, r_rdata1, r_wdata, r_mrdata;
    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_ena, f_wena;
    logic [7:0]  f_addr;
    logic [15:0] f_rdata0, f_rdata1, f_wdata, f_mrdata;

    logic [15:0] r_mem [256];
    logic [15:0] f_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Memory models: combinational read, a junk pattern when disabled.
    assign r_mrdata = r_ena ? r_mem[r_addr] : 16'hDEAD;
    assign f_mrdata = f_ena ? f_mem[f_addr] : 16'hDEAD;
    always @(posedge clk) if (r_ena && r_wena) r_mem[r_addr] <= r_wdata;
    always @(posedge clk) if (f_ena && f_wena) f_mem[f_addr] <= f_wdata;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(r_gnt0), .rdata0(r_rdata0), .rvalid0(r_rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(r_gnt1), .rdata1(r_rdata1), .rvalid1(r_rvalid1),
        .mem_ena(r_ena), .mem_wena(r_wena), .mem_addr(r_addr),
        .mem_wdata(r_wdata), .mem_rdata(r_mrdata)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .PRIO_MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(f_gnt0), .rdata0(f_rdata0), .rvalid0(f_rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(f_gnt1), .rdata1(f_rdata1), .rvalid1(f_rvalid1),
        .mem_ena(f_ena), .mem_wena(f_wena), .mem_addr(f_addr),
        .mem_wdata(f_wdata), .mem_rdata(f_mrdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then settle before checking.
    task automatic step(input logic rs,
                        input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                        input logic l1);
        @(posedge clk);
        #1;
        rst_n = rs;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #3;
    endtask

    logic exp_g1;
    logic lock_build;

    initial begin
`ifdef DMEM_ARB_LOCK_EN
        lock_build = 1'b1;
`else
        lock_build = 1'b0;
`endif
        // Reset with a pending write: must not reach memory.
        step(0, 1, 1, 8'h12, 16'h1111, 0, 0, 8'h00, 16'h0000, 0);
        chk("rst_gnt0", 32'(r_gnt0), 32'h0);
        chk("rst_ena", 32'(r_ena), 32'h0);
        chk("rst_fx_ena", 32'(f_ena), 32'h0);
        step(0, 1, 1, 8'h12, 16'h1111, 0, 0, 8'h00, 16'h0000, 0);
        chk("rst_rvalid0", 32'(r_rvalid0), 32'h0);
        chk("rst_rvalid1", 32'(r_rvalid1), 32'h0);
        chk("rst_rdata0", 32'(r_rdata0), 32'h0);
        chk("rst_rdata1", 32'(r_rdata1), 32'h0);
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("idle_ena", 32'(r_ena), 32'h0);
        chk("idle_gnt0", 32'(r_gnt0), 32'h0);

        // Port 0 write then read-back.
        step(1, 1, 1, 8'h12, 16'hBEEF, 0, 0, 8'h00, 16'h0000, 0);
        chk("wr_gnt0", 32'(r_gnt0), 32'h1);
        chk("wr_gnt1", 32'(r_gnt1), 32'h0);
        chk("wr_wena", 32'(r_wena), 32'h1);
        chk("wr_addr", 32'(r_addr), 32'h12);
        chk("wr_wdata", 32'(r_wdata), 32'hBEEF);
        step(1, 1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("rd_gnt0", 32'(r_gnt0), 32'h1);
        chk("rd_wena", 32'(r_wena), 32'h0);
        chk("wr_no_rvalid", 32'(r_rvalid0), 32'h0);
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("rd_rvalid0", 32'(r_rvalid0), 32'h1);
        chk("rd_rdata0", 32'(r_rdata0), 32'hBEEF);
        chk("rd_rvalid1", 32'(r_rvalid1), 32'h0);
        chk("nogrant_ena", 32'(r_ena), 32'h0);
        chk("nogrant_addr", 32'(r_addr), 32'h0);
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("rvalid_pulse", 32'(r_rvalid0), 32'h0);
        chk("rdata_hold", 32'(r_rdata0), 32'hBEEF);

        // Port 1 writes top address, port 0 reads it next cycle.
        step(1, 0, 0, 8'h00, 16'h0000, 1, 1, 8'hFF, 16'h00A5, 0);
        chk("xw_gnt1", 32'(r_gnt1), 32'h1);
        chk("xw_addr", 32'(r_addr), 32'hFF);
        chk("xw_wdata", 32'(r_wdata), 32'h00A5);
        step(1, 1, 0, 8'hFF, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("xr_gnt0", 32'(r_gnt0), 32'h1);
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("xr_rvalid0", 32'(r_rvalid0), 32'h1);
        chk("xr_rdata0", 32'(r_rdata0), 32'h00A5);
        chk("xr_fx_rdata0", 32'(f_rdata0), 32'h00A5);
        chk("xr_rdata1", 32'(r_rdata1), 32'h0);

        // Reset again: clears read data and favours port 0.
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("rst2_rdata0", 32'(r_rdata0), 32'h0);

        // Continuous contention on reads.
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 0, 8'h12, 16'h0000, 1, 0, 8'hFF, 16'h0000, 0);
            chk($sformatf("rr_gnt0_%0d", k), 32'(r_gnt0), 32'((k % 2) == 0));
            chk($sformatf("rr_gnt1_%0d", k), 32'(r_gnt1), 32'((k % 2) == 1));
            chk($sformatf("fx_gnt0_%0d", k), 32'(f_gnt0), 32'h1);
            chk($sformatf("fx_gnt1_%0d", k), 32'(f_gnt1), 32'h0);
            if (k > 0) begin
                chk($sformatf("rr_rvalid0_%0d", k), 32'(r_rvalid0), 32'((k % 2) == 1));
                chk($sformatf("rr_rvalid1_%0d", k), 32'(r_rvalid1), 32'((k % 2) == 0));
                chk($sformatf("fx_rdata0_%0d", k), 32'(f_rdata0), 32'hBEEF);
                if ((k % 2) == 0) chk($sformatf("rr_rdata1_%0d", k), 32'(r_rdata1), 32'h00A5);
                else              chk($sformatf("rr_rdata0_%0d", k), 32'(r_rdata0), 32'hBEEF);
            end
        end
        step(1, 0, 0, 8'h00, 16'h0000, 1, 0, 8'hFF, 16'h0000, 0);
        chk("fx_drop_gnt1", 32'(f_gnt1), 32'h1);
        chk("fx_drop_gnt0", 32'(f_gnt0), 32'h0);
        chk("rr_alone_gnt1", 32'(r_gnt1), 32'h1);
        chk("rr_last_rvalid1", 32'(r_rvalid1), 32'h1);

        // Lock sequence: port 0 goes first so port 1 wins the first tie.
        step(1, 1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("lk_pre_gnt0", 32'(r_gnt0), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0, 8'h12, 16'h0000, 1, 0, 8'hFF, 16'h0000, logic'(k < 3));
            exp_g1 = lock_build ? 1'b1 : ((k % 2) == 0);
            chk($sformatf("lk_gnt1_%0d", k), 32'(r_gnt1), 32'(exp_g1));
            chk($sformatf("lk_gnt0_%0d", k), 32'(r_gnt0), 32'(!exp_g1));
            chk($sformatf("lk_fx_gnt0_%0d", k), 32'(f_gnt0), 32'h1);
        end
        step(1, 1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
        chk("lk_post_gnt0", 32'(r_gnt0), 32'h1);
        chk("lk_post_rvalid1", 32'(r_rvalid1), 32'(lock_build));
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
